// File: rtl/arb_muxn_pkg.sv
// rtl/arb_muxn_pkg.sv - shared types and defaults for the arbitrating mux
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mux_pkg;
  typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;
  localparam int NB_DEFAULT = `WORD_WIDTH;
endpackage

// File: rtl/arb_muxn_rr_grant.sv
// rtl/arb_muxn_rr_grant.sv - combinational round-robin / fixed-priority grant
module rr_grant
  import mux_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  input  arb_mode_e        mode,
  output logic [NCH-1:0]   grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [2*NCH-1:0] w_dbl;
  logic [SEL_W-1:0] w_base;

  // Two copies of req let the search run ptr..ptr+NCH-1 without modulo wrap logic.
  assign w_dbl  = {req, req};
  assign w_base = (mode == ARB_FIXED) ? '0 : ptr;

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (w_dbl[int'(w_base) + j]) begin
        any = 1'b1;
        idx = (int'(w_base) + j >= NCH) ? SEL_W'(int'(w_base) + j - NCH)
                                        : SEL_W'(int'(w_base) + j);
      end
    end
    if (any) grant = NCH'(1) << idx;
  end
endmodule

// File: rtl/arb_muxn.sv
// rtl/arb_muxn.sv - N-way registered arbitrating mux with valid/ready channels
module arb_muxn
  import mux_pkg::*;
#(
  parameter int        NB    = NB_DEFAULT,
  parameter int        NCH   = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  parameter int        SEL_W = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*NB-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic              force_en,
  input  logic [SEL_W-1:0]  force_sel,
  output logic [NB-1:0]     out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  input  logic              err_clr
);
  logic [NB-1:0]    r_data;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;
  logic             r_err;

  logic [NCH-1:0]   w_req;
  logic [NCH-1:0]   w_grant;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_force_bad;
  logic             w_load_en;
  logic             w_xfer;

  // An out-of-range index only exists when NCH does not fill the SEL_W space.
  generate
    if ((1 << SEL_W) == NCH) begin : g_no_oor
      assign w_force_bad = 1'b0;
    end else begin : g_oor
      assign w_force_bad = force_en &&
                           ({{(32 - SEL_W){1'b0}}, force_sel} >= 32'(NCH));
    end
  endgenerate

  assign w_req = !force_en   ? in_valid :
                 w_force_bad ? '0       :
                 (in_valid & (NCH'(1) << force_sel));

  rr_grant #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_grant (
    .req   (w_req),
    .ptr   (r_ptr),
    .mode  (MODE),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  assign w_load_en = !r_valid || out_ready;
  assign in_ready  = w_grant & {NCH{w_load_en & rst_n}};
  assign w_xfer    = w_any && w_load_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load_en) begin
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_data <= in_data[w_idx*NB +: NB];
          r_sel  <= w_idx;
        end
      end
      if (MODE == ARB_RR && w_xfer)
        r_ptr <= (w_idx == SEL_W'(NCH - 1)) ? '0 : w_idx + SEL_W'(1);
      if (w_force_bad)  r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;
  assign err       = r_err;
endmodule
